// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: registered two-master Wishbone arbiter.
// Master 0 is the CPU and master 1 is the DMA engine. Both share one slave port.
// Ownership is round-robin. A master keeps ownership for its whole bus cycle.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to add a stall counter and the
// ABORT/WREL states. A stalled transfer is then ended with err to the owner.
// Without that macro the owner keeps the bus indefinitely.
module wb_rr_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_adr,
    input  logic [DATA_WIDTH-1:0]   m0_dat_w,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_dat_r,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_adr,
    input  logic [DATA_WIDTH-1:0]   m1_dat_w,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_dat_r,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH-1:0]   s_dat_w,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic [DATA_WIDTH-1:0]   s_dat_r,

    output logic                    o_owner,
    output logic                    o_busy
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OWN0  = 3'd1;
    localparam logic [2:0] ST_OWN1  = 3'd2;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [2:0] ST_ABORT = 3'd3;
    localparam logic [2:0] ST_WREL  = 3'd4;
`endif

    // Both master ports are gathered into arrays, so the rest of the logic can
    // index them by owner.
    logic [1:0]            mst_cyc;
    logic [1:0]            mst_stb;
    logic [1:0]            mst_we;
    logic [ADDR_WIDTH-1:0] mst_adr   [2];
    logic [DATA_WIDTH-1:0] mst_dat_w [2];
    logic [SEL_WIDTH-1:0]  mst_sel   [2];
    logic [1:0]            mst_ack;
    logic [1:0]            mst_err;
    logic [DATA_WIDTH-1:0] mst_dat_r [2];

    assign mst_cyc      = {m1_cyc, m0_cyc};
    assign mst_stb      = {m1_stb, m0_stb};
    assign mst_we       = {m1_we,  m0_we};
    assign mst_adr[0]   = m0_adr;
    assign mst_adr[1]   = m1_adr;
    assign mst_dat_w[0] = m0_dat_w;
    assign mst_dat_w[1] = m1_dat_w;
    assign mst_sel[0]   = m0_sel;
    assign mst_sel[1]   = m1_sel;

    assign m0_ack   = mst_ack[0];
    assign m0_err   = mst_err[0];
    assign m0_dat_r = mst_dat_r[0];
    assign m1_ack   = mst_ack[1];
    assign m1_err   = mst_err[1];
    assign m1_dat_r = mst_dat_r[1];

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       last_owner_reg;   // tie-break memory; reset to 1 so m0 wins first
    logic       owner_reg;        // last granted master, reported on o_owner
    logic       arb_valid;
    logic       arb_idx;
    logic       take_arb;
    logic       grant;
    logic       owner_cyc;
    logic       own_en;           // an OWNx state: the request/response path is live
    logic       abort_en;         // the one-cycle error pulse to the owner
    logic       tmo_hit;

    assign owner_cyc = mst_cyc[owner_reg];
    assign own_en    = (state_reg == ST_OWN0) || (state_reg == ST_OWN1);
    assign o_owner   = owner_reg;
    assign o_busy    = (state_reg != ST_IDLE);

    // Round-robin choice: a single requester wins; on a tie, the master that
    // was not granted last time wins.
    always_comb begin
        arb_valid = |mst_cyc;
        arb_idx   = 1'b0;
        if (mst_cyc == 2'b11) begin
            arb_idx = ~last_owner_reg;
        end else if (mst_cyc[1]) begin
            arb_idx = 1'b1;
        end
    end

    // Next-state logic. Arbitration takes place in IDLE and after the owner
    // releases cyc, so a waiting master is handed the bus without an idle cycle.
    always_comb begin
        state_next = state_reg;
        take_arb   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                take_arb = 1'b1;
            end
            ST_OWN0, ST_OWN1: begin
                if (!owner_cyc) begin
                    take_arb = 1'b1;
                end else if (tmo_hit) begin
`ifdef WB_ARB_TIMEOUT_EN
                    state_next = ST_ABORT;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                state_next = ST_WREL;
            end
            ST_WREL: begin
                if (!owner_cyc) begin
                    take_arb = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (take_arb) begin
            if (arb_valid) begin
                state_next = arb_idx ? ST_OWN1 : ST_OWN0;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    assign grant = take_arb & arb_valid;

    // Registered FSM state and ownership bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= 1'b1;
            owner_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                last_owner_reg <= arb_idx;
                owner_reg      <= arb_idx;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] tmo_cnt_reg;
    logic                 stalled;

    // A stalled cycle is a strobe with no response. An ack in the same cycle
    // as the limit therefore prevents the abort.
    assign stalled  = own_en && owner_cyc && s_stb && !s_ack && !s_err;
    assign tmo_hit  = stalled && (tmo_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign abort_en = (state_reg == ST_ABORT);

    // Counts consecutive stalled cycles. Any state change or any gap in the
    // stall clears it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt_reg <= '0;
        end else if ((state_next != state_reg) || !stalled) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign abort_en   = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES < 2);
`endif

    // Slave request path: the owner's request is passed through combinationally
    // in OWNx states. The slave port is quiet in every other state.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        if (own_en) begin
            s_cyc   = mst_cyc[owner_reg];
            s_stb   = mst_stb[owner_reg];
            s_we    = mst_we[owner_reg];
            s_adr   = mst_adr[owner_reg];
            s_dat_w = mst_dat_w[owner_reg];
            s_sel   = mst_sel[owner_reg];
        end
    end

    // Response path: only the owner sees slave responses. The non-owner sees
    // zeros. During the abort cycle the owner gets a single err pulse.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic is_owner;
            assign is_owner      = (owner_reg == 1'(gi));
            assign mst_ack[gi]   = own_en & is_owner & s_ack;
            assign mst_err[gi]   = is_owner & ((own_en & s_err) | abort_en);
            assign mst_dat_r[gi] = (own_en && is_owner) ? s_dat_r : '0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed testbench for wb_rr_arbiter with TIMEOUT_CYCLES = 8.
// Each stimulus cycle begins 1 time unit after a rising edge.
// Outputs are sampled on the falling edge.
module tb_wb_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat_w;
    logic [SW-1:0] m0_sel;
    logic          m0_ack, m0_err;
    logic [DW-1:0] m0_dat_r;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat_w;
    logic [SW-1:0] m1_sel;
    logic          m1_ack, m1_err;
    logic [DW-1:0] m1_dat_r;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w;
    logic [SW-1:0] s_sel;
    logic          s_ack, s_err;
    logic [DW-1:0] s_dat_r;
    logic          o_owner, o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    wb_rr_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_dat_w (m0_dat_w),
        .m0_sel   (m0_sel),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_dat_r (m0_dat_r),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_dat_w (m1_dat_w),
        .m1_sel   (m1_sel),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_dat_r (m1_dat_r),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_sel    (s_sel),
        .s_ack    (s_ack),
        .s_err    (s_err),
        .s_dat_r  (s_dat_r),
        .o_owner  (o_owner),
        .o_busy   (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
        s_ack = 0; s_err = 0; s_dat_r = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {s_cyc, s_stb, s_we, s_sel, m0_ack, m0_err, m1_ack, m1_err,
                             o_owner, o_busy}, 64'd0);
        chk({tag, "_req"},  {s_adr, s_dat_w}, 64'd0);
        chk({tag, "_rdat"}, {m0_dat_r, m1_dat_r}, 64'd0);
    endtask

    // This task returns at the start of "cycle 0", the first cycle without reset.
    task automatic do_reset(input string tag);
        i_rst_n = 0;
        idle_inputs();
        next_cycle();
        next_cycle();
        sample();
        chk_all_zero(tag);
        next_cycle();
        i_rst_n = 1;
    endtask

    // Bound on the whole run, in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- Single-master read ----
        do_reset("rst1");
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        sample();
        chk("rd_c0_scyc", s_cyc, 0);
        next_cycle();                                       // cycle 1
        sample();
        chk("rd_c1_scyc", s_cyc, 1);
        chk("rd_c1_sadr", s_adr, 32'h10);
        chk("rd_c1_owner", o_owner, 0);
        chk("rd_c1_m0ack", m0_ack, 0);
        next_cycle();                                       // cycle 2
        s_ack = 1; s_dat_r = 32'hDEADBEEF;
        sample();
        chk("rd_c2_m0ack", m0_ack, 1);
        chk("rd_c2_m0dat", m0_dat_r, 32'hDEADBEEF);
        chk("rd_c2_m1ack", m1_ack, 0);
        chk("rd_c2_m1dat", m1_dat_r, 0);
        next_cycle();                                       // cycle 3
        s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_stb = 0;
        sample();
        chk("rd_c3_scyc", s_cyc, 0);
        chk("rd_c3_m1ack", m1_ack, 0);
        next_cycle();                                       // cycle 4: IDLE
        sample();
        chk("rd_c4_busy", o_busy, 0);
        chk("rd_c4_owner", o_owner, 0);

        // ---- Tie after reset, round-robin handover, held ownership ----
        do_reset("rst2");
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h20;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h30;
        next_cycle();                                       // cycle 1
        s_ack = 1; s_dat_r = 32'hCAFE0000;
        sample();
        chk("tie_owner", o_owner, 0);
        chk("tie_scyc", s_cyc, 1);
        chk("tie_sadr", s_adr, 32'h20);
        chk("tie_m0ack", m0_ack, 1);
        chk("tie_m1ack", m1_ack, 0);
        chk("tie_m1dat", m1_dat_r, 0);
        next_cycle();                                       // cycle 2: m0 releases
        s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_stb = 0;
        sample();
        chk("ho_c2_scyc", s_cyc, 0);
        chk("ho_c2_busy", o_busy, 1);
        next_cycle();                                       // cycle 3: m1 owns
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h50;
        sample();
        chk("ho_c3_owner", o_owner, 1);
        chk("ho_c3_scyc", s_cyc, 1);
        chk("ho_c3_sadr", s_adr, 32'h30);
        chk("ho_c3_busy", o_busy, 1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            m1_we = 1; m1_adr = 32'h100 + 32'(i); m1_dat_w = 32'hA5A50000 + 32'(i);
            m1_sel = 4'(i + 1); s_ack = 1;
            sample();
            chk($sformatf("wr%0d_swe", i), s_we, 1);
            chk($sformatf("wr%0d_sadr", i), s_adr, 32'h100 + 32'(i));
            chk($sformatf("wr%0d_sdat", i), s_dat_w, 32'hA5A50000 + 32'(i));
            chk($sformatf("wr%0d_ssel", i), s_sel, 4'(i + 1));
            chk($sformatf("wr%0d_m1ack", i), m1_ack, 1);
            chk($sformatf("wr%0d_m0ack", i), m0_ack, 0);
            chk($sformatf("wr%0d_owner", i), o_owner, 1);
        end
        next_cycle();                                       // m1 releases
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        sample();
        chk("hold_rel_scyc", s_cyc, 0);
        chk("hold_rel_owner", o_owner, 1);
        next_cycle();
        sample();
        chk("hold_m0_owner", o_owner, 0);
        chk("hold_m0_scyc", s_cyc, 1);
        chk("hold_m0_sadr", s_adr, 32'h50);
        chk("hold_m0_swe", s_we, 0);
        next_cycle();
        m0_cyc = 0; m0_stb = 0;
        next_cycle();
        sample();
        chk("hold_idle_busy", o_busy, 0);

        // ---- Stalled slave: watchdog abort or indefinite hold ----
        do_reset("rst3");
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
        sample();
        chk("st_c0_scyc", s_cyc, 0);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 2) begin
                m1_cyc = 1; m1_stb = 1; m1_adr = 32'h80;
            end
            sample();
            chk($sformatf("st_c%0d_m0err", c), m0_err, 0);
            chk($sformatf("st_c%0d_scyc", c), s_cyc, 1);
        end
`ifdef WB_ARB_TIMEOUT_EN
        next_cycle();                                       // cycle 9: ABORT
        sample();
        chk("tmo_c9_m0err", m0_err, 1);
        chk("tmo_c9_scyc", s_cyc, 0);
        chk("tmo_c9_sstb", s_stb, 0);
        chk("tmo_c9_m1err", m1_err, 0);
        chk("tmo_c9_owner", o_owner, 0);
        next_cycle();                                       // cycle 10: WREL
        m0_cyc = 0; m0_stb = 0;
        sample();
        chk("tmo_c10_m0err", m0_err, 0);
        chk("tmo_c10_scyc", s_cyc, 0);
        chk("tmo_c10_busy", o_busy, 1);
`else
        for (int c = 9; c <= 12; c++) begin
            next_cycle();
            if (c == 12) s_err = 1;
            sample();
            chk($sformatf("hold_c%0d_scyc", c), s_cyc, 1);
            chk($sformatf("hold_c%0d_m0err", c), m0_err, (c == 12) ? 1 : 0);
            chk($sformatf("hold_c%0d_m1err", c), m1_err, 0);
        end
        next_cycle();
        s_err = 0; m0_cyc = 0; m0_stb = 0;
        sample();
        chk("hold_rel_m0err", m0_err, 0);
`endif
        next_cycle();                                       // m1 granted
        sample();
        chk("st_m1_owner", o_owner, 1);
        chk("st_m1_scyc", s_cyc, 1);
        chk("st_m1_sadr", s_adr, 32'h80);

        // ---- Reset while m1 owns with a slave response pending ----
        next_cycle();
        m1_we = 1; m1_dat_w = 32'h55AA55AA; m1_sel = 4'hF;
        s_ack = 1; s_dat_r = 32'h12345678;
        i_rst_n = 0;
        sample();
        chk("mr_pre_m1ack", m1_ack, 1);
        next_cycle();
        sample();
        chk_all_zero("mr_post");
        next_cycle();                                       // cycle 0 after reset
        i_rst_n = 1;
        idle_inputs();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h11;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h22;
        sample();
        chk("mr_c0_busy", o_busy, 0);
        next_cycle();
        sample();
        chk("mr_tie_owner", o_owner, 0);
        chk("mr_tie_sadr", s_adr, 32'h11);
        chk("mr_tie_busy", o_busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
